// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin arbiter that lends one shared ALU/RAM unit bus to N_THREADS cores.
// One operation in flight at a time; the result returns with a one-cycle valid pulse to its owner.
module unit_arbiter #(
   parameter int N_THREADS    = 4,
   parameter int SEL_W        = 2,
   parameter int UNIT_SEL_RAM = 1,
   parameter int RAM_LATENCY  = 2,
   parameter int ALU_LATENCY  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_THREADS-1:0]       req,
   input  logic [N_THREADS*SEL_W-1:0] req_sel,
   input  logic [N_THREADS*32-1:0]    req_ctrl,
   input  logic [N_THREADS*32-1:0]    req_in0,
   input  logic [N_THREADS*32-1:0]    req_in1,
   output logic [N_THREADS-1:0]       gnt,
   output logic [N_THREADS-1:0]       resp_valid,
   output logic [31:0]                resp_data,
   output logic [SEL_W-1:0]           unit_sel,
   output logic [31:0]                unit_ctrl,
   output logic [31:0]                unit_in0,
   output logic [31:0]                unit_in1,
   input  logic [31:0]                unit_out,
   output logic                       busy
);
   localparam int IDX_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [31:0]        ctrl_q, ctrl_d;
   logic [31:0]        in0_q, in0_d;
   logic [31:0]        in1_q, in1_d;
   logic [31:0]        data_q, data_d;

   logic               any_req;
   logic [IDX_W-1:0]   pick, idx;
   logic [SEL_W-1:0]   pick_sel;
   logic [31:0]        pick_ctrl, pick_in0, pick_in1;

   // Search downward so the candidate closest to rr_ptr+1 is written last and wins.
   always_comb begin
      any_req = |req;
      pick    = '0;
      idx     = '0;
      for (int k = N_THREADS; k >= 1; k--) begin
         idx = IDX_W'((int'(rr_ptr_q) + k) % N_THREADS);
         if (req[idx]) pick = idx;
      end
   end

   always_comb begin
      pick_sel  = '0;
      pick_ctrl = '0;
      pick_in0  = '0;
      pick_in1  = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         if (pick == IDX_W'(i)) begin
            pick_sel  = req_sel[i*SEL_W +: SEL_W];
            pick_ctrl = req_ctrl[i*32 +: 32];
            pick_in0  = req_in0[i*32 +: 32];
            pick_in1  = req_in1[i*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      ctrl_d     = ctrl_q;
      in0_d      = in0_q;
      in1_d      = in1_q;
      data_d     = data_q;
      gnt        = '0;
      resp_valid = '0;
      unit_sel   = '0;
      unit_ctrl  = '0;
      unit_in0   = '0;
      unit_in1   = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt[pick] = 1'b1;
               sel_d     = pick_sel;
               ctrl_d    = pick_ctrl;
               in0_d     = pick_in0;
               in1_d     = pick_in1;
               owner_d   = pick;
               rr_ptr_d  = pick;
               cnt_d     = (pick_sel == SEL_W'(UNIT_SEL_RAM)) ? CNT_W'(RAM_LATENCY)
                                                              : CNT_W'(ALU_LATENCY);
               state_d   = BUSY;
            end
         end
         BUSY: begin
            unit_sel  = sel_q;
            unit_ctrl = ctrl_q;
            unit_in0  = in0_q;
            unit_in1  = in1_q;
            if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = unit_out;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[owner_q] = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDX_W'(N_THREADS - 1);
         owner_q  <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         ctrl_q   <= '0;
         in0_q    <= '0;
         in1_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         ctrl_q   <= ctrl_d;
         in0_q    <= in0_d;
         in1_q    <= in1_d;
         data_q   <= data_d;
      end
   end

   assign resp_data = data_q;
   assign busy      = (state_q != IDLE);

   // Handshake invariants: single-owner grant/response, never in the same cycle.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
   a_rv_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0(resp_valid));
   a_no_overlap: assert property (@(posedge clk) disable iff (!rst) !((|gnt) && (|resp_valid)));

endmodule

// File: tb/tb_unit_arbiter.sv
// Bench for unit_arbiter: cycle-window model checked every cycle plus directed literal checks.
module tb_unit_arbiter;
   localparam int N  = 4;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N*SW-1:0]   req_sel;
   logic [N*32-1:0]   req_ctrl, req_in0, req_in1;
   logic [N-1:0]      gnt, resp_valid;
   logic [31:0]       resp_data, unit_ctrl, unit_in0, unit_in1, unit_out;
   logic [SW-1:0]     unit_sel;
   logic              busy;

   always #5 clk = ~clk;

   unit_arbiter #(.N_THREADS(N), .SEL_W(SW), .UNIT_SEL_RAM(1),
                  .RAM_LATENCY(2), .ALU_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .req_ctrl(req_ctrl),
      .req_in0(req_in0), .req_in1(req_in1), .gnt(gnt), .resp_valid(resp_valid),
      .resp_data(resp_data), .unit_sel(unit_sel), .unit_ctrl(unit_ctrl),
      .unit_in0(unit_in0), .unit_in1(unit_in1), .unit_out(unit_out), .busy(busy)
   );

   // Shared units: combinational ALU, RAM with a registered read port.
   function automatic logic [31:0] alu_fn(input logic [31:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      case (c)
         32'd0:   return a + b;
         32'd1:   return a - b;
         32'd2:   return a ^ b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] ram_fn(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : a * 32'd3 + 32'd1;
   endfunction

   logic [31:0] ram_q;
   always @(posedge clk) ram_q <= ram_fn(unit_in0);
   assign unit_out = (unit_sel == 2'd1) ? ram_q : alu_fn(unit_ctrl, unit_in0, unit_in1);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Model: an accepted op at cycle c owns the bus for c+1..c+L, responds at c+L+1,
   // and the arbiter is free again from c+L+2.
   int          cyc = 0;
   int          idle_from = 0, bs = -10, be = -10, rc = -10;
   int          last = N - 1, own = 0;
   logic [SW-1:0] m_sel = '0;
   logic [31:0] m_ctrl = '0, m_in0 = '0, m_in1 = '0, m_pend = '0, m_data = '0;

   always @(negedge clk) begin : cmp
      logic [N-1:0]  e_gnt, e_rv;
      logic [SW-1:0] e_sel;
      logic [31:0]   e_ctrl, e_in0, e_in1;
      logic          e_busy;
      int            pk, t, lat;
      if (!rst) begin
         chk("mdl_rst_gnt", 32'(gnt), 32'd0);
         chk("mdl_rst_rv", 32'(resp_valid), 32'd0);
         chk("mdl_rst_busy", 32'(busy), 32'd0);
         chk("mdl_rst_bus", 32'(unit_sel) | unit_ctrl | unit_in0 | unit_in1, 32'd0);
         chk("mdl_rst_data", resp_data, 32'd0);
         idle_from = cyc; bs = -10; be = -10; rc = -10;
         last = N - 1; own = 0; m_data = '0;
      end else begin
         if (cyc == rc) m_data = m_pend;
         pk = -1;
         if (cyc >= idle_from && req != '0) begin
            for (int k = 1; k <= N; k++) begin
               t = (last + k) % N;
               if (((req >> t) & N'(1)) != '0) begin
                  pk = t;
                  break;
               end
            end
         end
         e_gnt = (pk >= 0) ? (N'(1) << pk) : '0;
         e_rv  = (cyc == rc) ? (N'(1) << own) : '0;
         e_busy = (cyc >= bs) && (cyc <= rc);
         if (cyc >= bs && cyc <= be) begin
            e_sel = m_sel; e_ctrl = m_ctrl; e_in0 = m_in0; e_in1 = m_in1;
         end else begin
            e_sel = '0; e_ctrl = '0; e_in0 = '0; e_in1 = '0;
         end
         chk("mdl_gnt", 32'(gnt), 32'(e_gnt));
         chk("mdl_rv", 32'(resp_valid), 32'(e_rv));
         chk("mdl_busy", 32'(busy), 32'(e_busy));
         chk("mdl_sel", 32'(unit_sel), 32'(e_sel));
         chk("mdl_ctrl", unit_ctrl, e_ctrl);
         chk("mdl_in0", unit_in0, e_in0);
         chk("mdl_in1", unit_in1, e_in1);
         chk("mdl_data", resp_data, m_data);
         if (pk >= 0) begin
            m_sel  = SW'(req_sel >> (pk * SW));
            m_ctrl = 32'(req_ctrl >> (pk * 32));
            m_in0  = 32'(req_in0 >> (pk * 32));
            m_in1  = 32'(req_in1 >> (pk * 32));
            own = pk; last = pk;
            lat = (m_sel == 2'd1) ? 2 : 1;
            bs = cyc + 1; be = cyc + lat; rc = cyc + lat + 1; idle_from = cyc + lat + 2;
            m_pend = (m_sel == 2'd1) ? ram_fn(m_in0) : alu_fn(m_ctrl, m_in0, m_in1);
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int t, input logic [SW-1:0] s, input logic [31:0] c,
                        input logic [31:0] a, input logic [31:0] b);
      req_sel[t*SW +: SW] = s;
      req_ctrl[t*32 +: 32] = c;
      req_in0[t*32 +: 32]  = a;
      req_in1[t*32 +: 32]  = b;
      req = req | (N'(1) << t);
   endtask

   // Returns at the falling edge of the grant cycle (or after the budget expires).
   task automatic wait_gnt(input int t, input string nm);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (((gnt >> t) & N'(1)) != '0) hit = 1'b1;
         else step();
      end
      chk(nm, 32'(hit), 32'd1);
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
      return -1;
   endfunction

   initial begin
      int order[$];
      int at[$];
      int exp_rr[6];
      int exp_fr[2];
      exp_rr = '{0, 1, 2, 3, 0, 1};
      exp_fr = '{0, 3};
      rst = 1'b0; req = '0; req_sel = '0; req_ctrl = '0; req_in0 = '0; req_in1 = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_data", resp_data, 32'd0);
      step(); rst = 1'b1; step();

      // Single ALU op on thread 2.
      drive(2, 2'd2, 32'd0, 32'd5, 32'd7);
      wait_gnt(2, "t1_wait");
      chk("t1_gnt", 32'(gnt), 32'h4);
      step(); req = '0;
      @(negedge clk);
      chk("t1_sel", 32'(unit_sel), 32'd2);
      chk("t1_ctrl", unit_ctrl, 32'd0);
      chk("t1_in0", unit_in0, 32'd5);
      chk("t1_in1", unit_in1, 32'd7);
      step(); @(negedge clk);
      chk("t1_rv", 32'(resp_valid), 32'h4);
      chk("t1_data", resp_data, 32'd12);
      step();
      chk("t1_pin_model", m_data, 32'd12);

      // RAM op on thread 0.
      drive(0, 2'd1, 32'd0, 32'h40, 32'd0);
      wait_gnt(0, "t2_wait");
      chk("t2_gnt", 32'(gnt), 32'h1);
      step(); req = '0;
      @(negedge clk);
      chk("t2_busy1", 32'(busy), 32'd1);
      chk("t2_sel1", 32'(unit_sel), 32'd1);
      chk("t2_in0_1", unit_in0, 32'h40);
      step(); @(negedge clk);
      chk("t2_busy2", 32'(busy), 32'd1);
      chk("t2_in0_2", unit_in0, 32'h40);
      chk("t2_rv2", 32'(resp_valid), 32'd0);
      step(); @(negedge clk);
      chk("t2_busy3", 32'(busy), 32'd1);
      chk("t2_sel3", 32'(unit_sel), 32'd0);
      chk("t2_rv3", 32'(resp_valid), 32'h1);
      chk("t2_data", resp_data, 32'hDEADBEEF);
      step();
      chk("t2_pin_model", m_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("t2_idle", 32'(busy), 32'd0);
      step();

      // Round robin: park the pointer on thread 3, then hold all requests.
      drive(3, 2'd2, 32'd1, 32'd50, 32'd8);
      wait_gnt(3, "t3_pre");
      step(); req = '0;
      repeat (3) step();
      for (int i = 0; i < N; i++) drive(i, 2'd2, 32'(i), 32'(10 * i + 3), 32'(i + 1));
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         @(negedge clk);
         if (gnt != '0) begin
            order.push_back(oh_idx(gnt));
            at.push_back(c);
         end
         step();
      end
      req = '0;
      chk("rr_count", 32'(order.size()), 32'd6);
      for (int k = 0; k < order.size(); k++) begin
         chk("rr_order", 32'(order[k]), 32'(exp_rr[k]));
         if (k > 0) chk("rr_gap", 32'(at[k] - at[k-1]), 32'd3);
      end

      // Fairness across the wrap: 3 keeps requesting, 0 joins.
      repeat (3) step();
      order.delete(); at.delete();
      drive(3, 2'd2, 32'd0, 32'd1, 32'd2);
      wait_gnt(3, "t4_pre");
      step();
      drive(0, 2'd2, 32'd0, 32'd3, 32'd4);
      for (int c = 0; c < 30 && order.size() < 2; c++) begin
         @(negedge clk);
         if (gnt != '0) order.push_back(oh_idx(gnt));
         step();
      end
      req = '0;
      chk("fr_count", 32'(order.size()), 32'd2);
      for (int k = 0; k < order.size() && k < 2; k++) chk("fr_order", 32'(order[k]), 32'(exp_fr[k]));

      // Operands change after grant.
      repeat (3) step();
      drive(1, 2'd2, 32'd0, 32'd9, 32'd1);
      wait_gnt(1, "t5_wait");
      step(); req = '0; req_in0[63:32] = 32'd99;
      @(negedge clk);
      chk("t5_in0", unit_in0, 32'd9);
      step(); @(negedge clk);
      chk("t5_rv", 32'(resp_valid), 32'h2);
      chk("t5_data", resp_data, 32'd10);
      step();

      // Async reset in the middle of a RAM op.
      repeat (2) step();
      drive(0, 2'd1, 32'd0, 32'h44, 32'd0);
      wait_gnt(0, "t6_wait");
      step(); req = '0;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("t6_sel", 32'(unit_sel), 32'd0);
      chk("t6_in0", unit_in0, 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      step(); step(); rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t6_no_rv", 32'(resp_valid), 32'd0);
         step();
      end
      for (int i = 0; i < N; i++) drive(i, 2'd2, 32'd2, 32'(i + 20), 32'd5);
      @(negedge clk);
      chk("t6_first", 32'(gnt), 32'h1);
      step(); req = '0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end
endmodule

// File: doc/unit_arbiter.md
Name: unit_arbiter

Overview:
- Shares one set of functional units (ALU, RAM) between N_THREADS thread cores.
- Each thread raises a request carrying unit_sel/unit_ctrl/unit_in[1:0]. The arbiter grants one request at a time in round-robin order and drives the shared unit bus from latched operands.
- It holds the bus for the unit's latency, then returns unit_out to the owning thread with a one-cycle valid pulse.
- Sits between the thread instances and the unit mux at core top level.

Parameters:
- N_THREADS, 4, number of requesting threads (2..8).
- SEL_W, 2, width of unit_sel.
- UNIT_SEL_RAM, 1, unit_sel code that selects RAM.
- RAM_LATENCY, 2, cycles the RAM needs before unit_out is valid (1..7).
- ALU_LATENCY, 1, cycles for every non-RAM unit (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- req  in  N_THREADS  per-thread request; held with operands stable until gnt.
- req_sel  in  N_THREADS*SEL_W  per-thread unit select, thread i at slice i.
- req_ctrl  in  N_THREADS*32  per-thread unit control word.
- req_in0  in  N_THREADS*32  per-thread operand 0.
- req_in1  in  N_THREADS*32  per-thread operand 1.
- gnt  out  N_THREADS  one-hot, one-cycle pulse: request accepted, operands latched.
- resp_valid  out  N_THREADS  one-hot, one-cycle pulse: resp_data valid for that thread.
- resp_data  out  32  result, shared by all threads.
- unit_sel  out  SEL_W  to shared units.
- unit_ctrl  out  32  to shared units.
- unit_in0  out  32  to shared units.
- unit_in1  out  32  to shared units.
- unit_out  in  32  result from the selected unit.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=N_THREADS-1, owner=0, cnt=0.
  - All latched operand registers and resp_data clear to 0.
  - gnt=0, resp_valid=0, unit_sel/ctrl/in0/in1=0, busy=0.
- Reset during BUSY or RESP abandons the operation: no gnt and no resp_valid are issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from (rr_ptr+1) mod N_THREADS upward with wrap.
  - gnt[pick] is combinational and high this cycle only.
  - At the clock edge: latch that thread's sel/ctrl/in0/in1, set owner=pick, rr_ptr=pick.
  - Load cnt with RAM_LATENCY if sel==UNIT_SEL_RAM, else ALU_LATENCY. Go to BUSY.
  - With no request, stay in IDLE with the unit bus at 0.
- BUSY:
  - unit_sel/ctrl/in0/in1 are driven from the latched registers, stable for the whole state.
  - cnt>1: decrement and stay.
  - cnt==1: capture unit_out into resp_data and go to RESP.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle; resp_data holds the captured value.
  - Unit bus returns to 0. Go to IDLE.
  - resp_data keeps its value until the next capture.
- Timing: acceptance at cycle 0 gives resp_valid at cycle L+1 (L = selected latency).
- Throughput: the earliest next acceptance is cycle L+2, because new requests are accepted only in IDLE.
- Fairness: a thread granted last has lowest priority at the next arbitration, so no requester starves.
- req bits that are set in BUSY or RESP are ignored and not queued. The thread keeps req high until it sees gnt.
- A thread may keep req high after gnt. It is then treated as a new request at the next IDLE, in rr order.
- A req that drops before gnt is simply not considered; no error is raised.
- Operand changes after gnt have no effect, because the values are latched.
- At most one gnt bit and at most one resp_valid bit are ever set. gnt and resp_valid are never high in the same cycle.

Test Plan:
- Reset then single ALU request: thread 2 req, sel=2, ctrl=ADD, in0=5, in1=7; unit returns in0+in1.
  - Response: gnt=4'b0100 at cycle 0.
  - Unit bus = (2, ADD, 5, 7) at cycle 1.
  - resp_valid=4'b0100 with resp_data=12 at cycle 2.
- RAM latency: thread 0 req, sel=1, in0=0x40; model returns 0xDEADBEEF after 2 cycles.
  - Response: busy for cycles 1–3; unit bus held for cycles 1–2.
  - resp_valid[0] with resp_data=0xDEADBEEF at cycle 3.
- Round-robin: all four req held high continuously.
  - Response: grant order 0,1,2,3,0,1 with exactly L+2 cycles between successive gnts.
- Fairness with wrap: after a grant to thread 3, threads 0 and 3 both request.
  - Response: thread 0 is granted first, then thread 3.
- Operand stability: thread 1 changes in0 from 9 to 99 in the cycle after gnt.
  - Response: unit_in0 stays 9 and the result uses 9.
- Async reset mid-BUSY (RAM op, cycle 1):
  - Response: the bus clears to 0 immediately and no resp_valid appears.
  - The next request after reset release is granted to thread 0 when all threads request.
